// File: rtl/ctrl_pipe.sv
// ctrl_pipe: pipeline register chain for decoded control bundles.
// Each stage holds a valid bit and a WIDTH-bit control word. Stages can be
// stalled (the hold propagates backward to all earlier stages), flushed to a
// bubble, or loaded from the stage before them. Each load is masked so that
// fields which later stages no longer need are dropped. An invalid stage
// always holds a zero word. The number of valid stages is reported for the
// hazard unit.
module ctrl_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 3,
  parameter logic [STAGES*WIDTH-1:0] MASK = {16'h000F, 16'h00FF, 16'hFFFF}
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_ctrl,
  output logic                       in_ready,
  input  logic [STAGES-1:0]          stall,
  input  logic [STAGES-1:0]          flush,
  output logic [STAGES-1:0]          out_valid,
  output logic [STAGES*WIDTH-1:0]    out_ctrl,
  output logic [$clog2(STAGES+1)-1:0] inflight
);

  localparam int CNT_W = $clog2(STAGES + 1);

  // Masked load: a bubble always carries an all-zero word so that downstream
  // logic never sees stale fields behind a cleared valid bit.
  function automatic logic [WIDTH-1:0] f_load(input logic             v,
                                              input logic [WIDTH-1:0] c,
                                              input logic [WIDTH-1:0] m);
    return v ? (c & m) : '0;
  endfunction

  logic             r_valid [STAGES];
  logic [WIDTH-1:0] r_ctrl  [STAGES];

  logic [STAGES-1:0] w_hold;
  logic              w_src_valid [STAGES];
  logic [WIDTH-1:0]  w_src_ctrl  [STAGES];
  logic [CNT_W-1:0]  w_count;

  // Stage k is frozen when it or any later stage stalls.
  for (genvar k = 0; k < STAGES; k++) begin : g_hold
    assign w_hold[k] = |stall[STAGES-1:k];
  end

  assign in_ready = ~w_hold[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Source selection: the decoder feeds stage 0; every later stage takes
    // the previous one, except that a frozen predecessor hands over a bubble
    // so the same instruction is not duplicated into two stages.
    if (k == 0) begin : g_src_in
      assign w_src_valid[k] = in_valid;
      assign w_src_ctrl[k]  = in_ctrl;
    end else begin : g_src_prev
      assign w_src_valid[k] = r_valid[k-1] & ~w_hold[k-1];
      assign w_src_ctrl[k]  = r_ctrl[k-1];
    end

    // Stage register: flush wins over hold, hold wins over load.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_valid[k] <= 1'b0;
        r_ctrl[k]  <= '0;
      end else if (flush[k]) begin
        r_valid[k] <= 1'b0;
        r_ctrl[k]  <= '0;
      end else if (!w_hold[k]) begin
        r_valid[k] <= w_src_valid[k];
        r_ctrl[k]  <= f_load(w_src_valid[k], w_src_ctrl[k],
                             MASK[k*WIDTH +: WIDTH]);
      end
    end

    assign out_valid[k]                = r_valid[k];
    assign out_ctrl[k*WIDTH +: WIDTH]  = r_ctrl[k];
  end

  // Population count of the valid bits for the hazard unit.
  always_comb begin
    w_count = '0;
    for (int k = 0; k < STAGES; k++) begin
      w_count = w_count + CNT_W'(r_valid[k]);
    end
  end

  assign inflight = w_count;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Testbench for ctrl_pipe: directed scenarios followed by random traffic,
// all checked against a stage-array reference model.
module tb_ctrl_pipe;

  localparam int W = 16;
  localparam int S = 3;
  localparam logic [S*W-1:0] MASK = {16'h000F, 16'h00FF, 16'hFFFF};

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic [W-1:0]   in_ctrl;
  logic           in_ready;
  logic [S-1:0]   stall;
  logic [S-1:0]   flush;
  logic [S-1:0]   out_valid;
  logic [S*W-1:0] out_ctrl;
  logic [1:0]     inflight;

  int checks = 0;
  int errors = 0;

  // Reference model: one entry per stage.
  logic         mv [S];
  logic [W-1:0] mc [S];

  always #5 clk = ~clk;

  ctrl_pipe #(.WIDTH(W), .STAGES(S), .MASK(MASK)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ctrl  (in_ctrl),
    .in_ready (in_ready),
    .stall    (stall),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ctrl (out_ctrl),
    .inflight (inflight)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < S; k++) begin
      mv[k] = 1'b0;
      mc[k] = '0;
    end
  endtask

  // Next state of the pipe from the current inputs, per the stage rules.
  task automatic model_step();
    logic         nv [S];
    logic [W-1:0] nc [S];
    logic         h  [S];
    logic         sv;
    logic [W-1:0] sc;
    for (int k = 0; k < S; k++) begin
      h[k] = 1'b0;
      for (int j = k; j < S; j++) if (stall[j]) h[k] = 1'b1;
    end
    for (int k = 0; k < S; k++) begin
      if (flush[k]) begin
        nv[k] = 1'b0;
        nc[k] = '0;
      end else if (h[k]) begin
        nv[k] = mv[k];
        nc[k] = mc[k];
      end else begin
        if (k == 0) begin
          sv = in_valid;
          sc = in_ctrl;
        end else if (h[k-1]) begin
          sv = 1'b0;
          sc = '0;
        end else begin
          sv = mv[k-1];
          sc = mc[k-1];
        end
        nv[k] = sv;
        nc[k] = sv ? (sc & MASK[k*W +: W]) : '0;
      end
    end
    for (int k = 0; k < S; k++) begin
      mv[k] = nv[k];
      mc[k] = nc[k];
    end
  endtask

  task automatic chk_all(input string tag);
    logic [S-1:0]   ev;
    logic [S*W-1:0] ec;
    int             cnt;
    cnt = 0;
    for (int k = 0; k < S; k++) begin
      ev[k]          = mv[k];
      ec[k*W +: W]   = mc[k];
      cnt           += mv[k] ? 1 : 0;
    end
    chk({tag, ".valid"},    64'(out_valid), 64'(ev));
    chk({tag, ".ctrl"},     64'(out_ctrl),  64'(ec));
    chk({tag, ".inflight"}, 64'(inflight),  64'(cnt));
    chk({tag, ".in_ready"}, 64'(in_ready),  64'(stall == '0));
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  task automatic drive(input logic v, input logic [W-1:0] c);
    in_valid = v;
    in_ctrl  = c;
  endtask

  logic [W-1:0] s0, s1, s2;
  always_comb begin
    s0 = out_ctrl[0*W +: W];
    s1 = out_ctrl[1*W +: W];
    s2 = out_ctrl[2*W +: W];
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, '0);
    stall = '0;
    flush = '0;
    model_clear();

    // Reset state, asserted between edges
    #1 rst = 1'b0;
    #1 chk_all("reset");
    #1 rst = 1'b1;

    // Streaming
    drive(1'b1, 16'hAAAA); step("stream1");
    chk("stream1.s0", 64'(s0), 64'(16'hAAAA));
    drive(1'b1, 16'h1234); step("stream2");
    chk("stream2.s0", 64'(s0), 64'(16'h1234));
    chk("stream2.s1", 64'(s1), 64'(16'h00AA));
    drive(1'b1, 16'hFFFF); step("stream3");
    chk("stream3.s0", 64'(s0), 64'(16'hFFFF));
    chk("stream3.s1", 64'(s1), 64'(16'h0034));
    chk("stream3.s2", 64'(s2), 64'(16'h000A));
    chk("stream3.inflight", 64'(inflight), 64'd3);
    drive(1'b0, '0); step("stream4");
    chk("stream4.s1", 64'(s1), 64'(16'h00FF));
    chk("stream4.s2", 64'(s2), 64'(16'h0004));
    step("stream5");
    chk("stream5.s2", 64'(s2), 64'(16'h000F));

    // Middle stall
    drive(1'b1, 16'h1111); step("fillA");
    drive(1'b1, 16'h2222); step("fillB");
    drive(1'b1, 16'h3333); step("fillC");
    drive(1'b1, 16'h4444);
    stall = 3'b010;
    #1 chk("mstall.in_ready", 64'(in_ready), 64'd0);
    step("mstall1");
    chk("mstall1.s0", 64'(s0), 64'(16'h3333));
    chk("mstall1.s1", 64'(s1), 64'(16'h0022));
    chk("mstall1.v2", 64'(out_valid[2]), 64'd0);
    chk("mstall1.s2", 64'(s2), 64'd0);
    step("mstall2");
    stall = '0;
    step("mrelease");
    chk("mrelease.s2", 64'(s2), 64'(16'h0002));
    chk("mrelease.s0", 64'(s0), 64'(16'h4444));

    // Flush of stages 0 and 1 with a valid input waiting
    drive(1'b1, 16'h5555);
    flush = 3'b011;
    step("flush");
    chk("flush.s2", 64'(s2), 64'(16'h0003));
    chk("flush.inflight", 64'(inflight), 64'd1);
    flush = '0;

    // Flush beats stall on the same stage
    drive(1'b1, 16'h6666); step("fb1");
    drive(1'b1, 16'h7777); step("fb2");
    drive(1'b1, 16'h8888);
    stall = 3'b010;
    flush = 3'b010;
    #1 chk("fbs.in_ready", 64'(in_ready), 64'd0);
    step("fbs");
    chk("fbs.v1", 64'(out_valid[1]), 64'd0);
    chk("fbs.s0", 64'(s0), 64'(16'h7777));
    stall = '0;
    flush = '0;

    // Reset in the middle of operation, between edges
    drive(1'b1, 16'h9999); step("rfill1");
    drive(1'b1, 16'hABCD); step("rfill2");
    drive(1'b1, 16'hBEEF); step("rfill3");
    chk("rfill3.inflight", 64'(inflight), 64'd3);
    #2 rst = 1'b0;
    model_clear();
    #1 chk_all("midreset");
    chk("midreset.inflight", 64'(inflight), 64'd0);
    #1 rst = 1'b1;

    // Input bubble carrying garbage
    drive(1'b1, 16'h0F0F); step("bub_pre");
    drive(1'b0, 16'hDEAD); step("bubble");
    chk("bubble.v0", 64'(out_valid[0]), 64'd0);
    chk("bubble.s0", 64'(s0), 64'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), W'($urandom));
      for (int k = 0; k < S; k++) begin
        stall[k] = ($urandom_range(0, 5) == 0);
        flush[k] = ($urandom_range(0, 9) == 0);
      end
      if ($urandom_range(0, 99) == 0) begin
        #2 rst = 1'b0;
        model_clear();
        #1 chk_all("rnd_reset");
        #1 rst = 1'b1;
      end
      step("rnd");
      for (int k = 0; k < S; k++) begin
        if (!out_valid[k])
          chk("rnd.bubble_zero", 64'(out_ctrl[k*W +: W]), 64'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
